csr_file: RTL

//   Machine-mode CSR register file for the RV32I core; responder side of the execute stage's CSR access.

---
 rtl/csr_file_if.sv | 32 +++
 rtl/csr_file.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/csr_file_if.sv
// csr_file_if -- CSR access bus between the execute stage and the CSR file.
//
// Signals (names are from the CSR file's point of view):
//   csr_addr_i     12  CSR address of the instruction in execute
//   csr_we_i        1  write request
//   csr_wdata_i    32  new CSR value
//   csr_rdata_o    32  current CSR value (combinational)
//   illegal_csr_o   1  unimplemented address, or write to a read-only address
//
// Handshake: there is no valid/ready pair. Every cycle the execute stage
// presents an address and the CSR file answers combinationally in the same
// cycle; the responder is always ready. A write request commits on the next
// rising clock edge when the pipeline advances and the access is legal.
interface csr_file_if;
   logic [11:0] csr_addr_i;
   logic        csr_we_i;
   logic [31:0] csr_wdata_i;
   logic [31:0] csr_rdata_o;
   logic        illegal_csr_o;

   // Execute stage: drives the access, consumes the read data.
   modport master (
      output csr_addr_i, csr_we_i, csr_wdata_i,
      input  csr_rdata_o, illegal_csr_o
   );

   // CSR file: responds to the access.
   modport slave (
      input  csr_addr_i, csr_we_i, csr_wdata_i,
      output csr_rdata_o, illegal_csr_o
   );
endinterface

// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR register file for the RV32I core.
//
// Holds mstatus (MIE/MPIE), mtvec, mscratch, mepc, mcause and the 64-bit
// mcycle/minstret counters. Reads are combinational; writes, traps and MRET
// commit on the rising edge of i_clk while i_en is high. The cycle counter
// runs every cycle regardless of i_en.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_en             pipeline advance; gates write/retire/trap/mret
//   csr_bus          CSR access bus (slave side)
//   retire_i         one instruction retired this cycle
//   trap_i           take a trap this cycle (cause/pc below)
//   trap_cause_i     mcause value for the trap
//   trap_pc_i        PC of the trapping instruction
//   mret_i           MRET executing this cycle
//   trap_vector_o    {mtvec[31:2], 2'b00}
//   mepc_o           current mepc (MRET target)
module csr_file #(
   parameter int          N_param     = 32,
   parameter logic [31:0] MHARTID     = 32'd0,
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   csr_file_if.slave   csr_bus,
   input  logic        retire_i,
   input  logic        trap_i,
   input  logic [31:0] trap_cause_i,
   input  logic [31:0] trap_pc_i,
   input  logic        mret_i,
   output logic [31:0] trap_vector_o,
   output logic [31:0] mepc_o
);

   localparam logic [31:0] MISA_VAL = 32'h4000_0100;

   logic               mie_q, mie_d;
   logic               mpie_q, mpie_d;
   logic [31:0]        mtvec_q, mtvec_d;     // bits[1:0] held at 0
   logic [N_param-1:0] mscratch_q, mscratch_d;
   logic [31:0]        mepc_q, mepc_d;       // bits[1:0] held at 0
   logic [N_param-1:0] mcause_q, mcause_d;
   logic [63:0]        mcycle_q, mcycle_d;
   logic [63:0]        minstret_q, minstret_d;

   logic [31:0] mstatus_rd;
   logic [31:0] rdata;
   logic        impl;
   logic        illegal;
   logic        wr_ok;
   logic        trap_take;
   logic        mret_take;

   // MPP is hardwired to machine mode; only MIE and MPIE are stored.
   assign mstatus_rd = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

   always_comb begin
      rdata = 32'd0;
      impl  = 1'b1;
      case (csr_bus.csr_addr_i)
         12'h300: rdata = mstatus_rd;
         12'h301: rdata = MISA_VAL;
         12'h305: rdata = mtvec_q;
         12'h340: rdata = mscratch_q;
         12'h341: rdata = mepc_q;
         12'h342: rdata = mcause_q;
         12'hB00, 12'hC00: rdata = mcycle_q[31:0];
         12'hB80, 12'hC80: rdata = mcycle_q[63:32];
         12'hB02, 12'hC02: rdata = minstret_q[31:0];
         12'hB82, 12'hC82: rdata = minstret_q[63:32];
         12'hF11, 12'hF12, 12'hF13: rdata = 32'd0;
         12'hF14: rdata = MHARTID;
         default: impl = 1'b0;
      endcase
   end

   // addr[11:10] == 2'b11 is the read-only CSR space.
   assign illegal   = ~impl | (csr_bus.csr_we_i & (csr_bus.csr_addr_i[11:10] == 2'b11));
   assign wr_ok     = i_en & csr_bus.csr_we_i & ~illegal & ~trap_i;
   assign trap_take = i_en & trap_i;
   assign mret_take = i_en & mret_i & ~trap_i;

   assign csr_bus.csr_rdata_o   = rdata;
   assign csr_bus.illegal_csr_o = illegal;
   assign trap_vector_o         = mtvec_q;
   assign mepc_o                = mepc_q;

   always_comb begin
      mie_d      = mie_q;
      mpie_d     = mpie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      // Increments first; a counter write then replaces only the written half,
      // so the other half keeps the carry from the pre-write low word.
      mcycle_d   = mcycle_q + 64'd1;
      minstret_d = minstret_q + {63'd0, i_en & retire_i};

      if (wr_ok) begin
         case (csr_bus.csr_addr_i)
            12'h300: begin
               mie_d  = csr_bus.csr_wdata_i[3];
               mpie_d = csr_bus.csr_wdata_i[7];
            end
            12'h305: mtvec_d           = csr_bus.csr_wdata_i & ~32'h3;
            12'h340: mscratch_d        = csr_bus.csr_wdata_i;
            12'h341: mepc_d            = csr_bus.csr_wdata_i & ~32'h3;
            12'h342: mcause_d          = csr_bus.csr_wdata_i;
            12'hB00: mcycle_d[31:0]    = csr_bus.csr_wdata_i;
            12'hB80: mcycle_d[63:32]   = csr_bus.csr_wdata_i;
            12'hB02: minstret_d[31:0]  = csr_bus.csr_wdata_i;
            12'hB82: minstret_d[63:32] = csr_bus.csr_wdata_i;
            default: ;
         endcase
      end

      // MRET beats a same-cycle mstatus write; uses the pre-write MPIE.
      if (mret_take) begin
         mie_d  = mpie_q;
         mpie_d = 1'b1;
      end

      // wr_ok and mret_take already exclude trap_i, so this sees pre-edge state.
      if (trap_take) begin
         mepc_d   = trap_pc_i & ~32'h3;
         mcause_d = trap_cause_i;
         mpie_d   = mie_q;
         mie_d    = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         mie_q      <= 1'b0;
         mpie_q     <= 1'b0;
         mtvec_q    <= RESET_MTVEC & ~32'h3;
         mscratch_q <= '0;
         mepc_q     <= 32'd0;
         mcause_q   <= '0;
         mcycle_q   <= 64'd0;
         minstret_q <= 64'd0;
      end else begin
         mie_q      <= mie_d;
         mpie_q     <= mpie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mcycle_q   <= mcycle_d;
         minstret_q <= minstret_d;
      end
   end

endmodule
